// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the floating-point datapath blocks.
//   fp_class_t  : operand class (ZERO covers true zero and flushed subnormals)
//   fp_meta_t   : sign and operand classes carried alongside the datapath
//   fp_flags_t  : exception flags aligned with a result
//   fp_bias / fp_inf / fp_qnan / fp_classify : constant helpers, usable for
//   any exponent/fraction split with a total width up to FP_MAX_W bits.
// ---------------------------------------------------------------------------
package fp_pkg;

   localparam int unsigned FP_MAX_W = 64;

   typedef enum logic [1:0] {
      ZERO,
      NORM,
      INF,
      NAN
   } fp_class_t;

   typedef struct packed {
      logic      sign;
      fp_class_t cls_a;
      fp_class_t cls_b;
   } fp_meta_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic invalid;
   } fp_flags_t;

   function automatic int unsigned fp_bias(input int unsigned ew);
      return (32'd1 << (ew - 1)) - 32'd1;
   endfunction

   // Magnitude of +inf right-aligned in FP_MAX_W bits (sign bit clear).
   function automatic logic [FP_MAX_W-1:0] fp_inf(input int unsigned ew,
                                                   input int unsigned mw);
      return ((64'd1 << ew) - 64'd1) << mw;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
   function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned ew,
                                                    input int unsigned mw);
      return fp_inf(ew, mw) | (64'd1 << (mw - 1));
   endfunction

   function automatic fp_class_t fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic frac_nz);
      if (exp_zero)     return ZERO;
      else if (exp_ones) return frac_nz ? NAN : INF;
      else              return NORM;
   endfunction

endpackage

// File: rtl/fp_round_norm.sv
// ---------------------------------------------------------------------------
// fp_round_norm
// Combinational normalise / round / range check / pack for a raw mantissa
// product. Also intended for reuse by the adder datapath.
// Configuration macro: FP_MUL_ROUND_EN
//   defined   : round to nearest, ties to even
//   undefined : truncate toward zero
// Ports:
//   meta_i   : result sign and the two operand classes
//   exp_i    : biased exponent sum, EXPONENT_WIDTH+2 bits signed
//   prod_i   : (MANTISSA_WIDTH+1)^2 product, hidden bits included
//   result_o : packed {sign, exponent, fraction}
//   flags_o  : overflow / underflow / invalid
// ---------------------------------------------------------------------------
module fp_round_norm
   import fp_pkg::*;
#(
   parameter int unsigned EXPONENT_WIDTH = 8,
   parameter int unsigned MANTISSA_WIDTH = 23,
   localparam int unsigned W  = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
   localparam int unsigned PW = 2 * MANTISSA_WIDTH + 2
) (
   input  fp_meta_t                      meta_i,
   input  logic signed [EXPONENT_WIDTH+1:0] exp_i,
   input  logic [PW-1:0]                 prod_i,
   output logic [W-1:0]                  result_o,
   output fp_flags_t                     flags_o
);

   localparam int unsigned EW = EXPONENT_WIDTH;
   localparam int unsigned MW = MANTISSA_WIDTH;

   localparam logic [FP_MAX_W-1:0]   QNAN_F  = fp_qnan(EW, MW);
   localparam logic [FP_MAX_W-1:0]   INF_F   = fp_inf(EW, MW);
   localparam logic [W-1:0]          QNAN    = QNAN_F[W-1:0];
   localparam logic [W-2:0]          INF_MAG = INF_F[W-2:0];
   localparam logic signed [EW+1:0]  EXP_ONE = (EW+2)'(1);
   localparam logic signed [EW+1:0]  EXP_MAX = (EW+2)'((1 << EW) - 1);

   logic [PW-1:0]          prod_n;
   logic signed [EW+1:0]   exp_n;
   logic signed [EW+1:0]   exp_r;
   logic [MW-1:0]          frac_r;
   logic                   unused_bits;
   logic                   any_nan;
   logic                   inf_x_zero;
   logic                   any_inf;
   logic                   any_zero;

   // Left-align so the leading one always sits in the MSB; the fraction,
   // guard and sticky positions are then fixed.
   always_comb begin
      if (prod_i[PW-1]) begin
         prod_n = prod_i;
         exp_n  = exp_i + EXP_ONE;
      end else begin
         prod_n = prod_i << 1;
         exp_n  = exp_i;
      end
   end

`ifdef FP_MUL_ROUND_EN
   logic          guard;
   logic          sticky;
   logic          round_up;
   logic [MW:0]   frac_sum;

   always_comb begin
      guard    = prod_n[MW];
      sticky   = |prod_n[MW-1:0];
      round_up = guard & (sticky | prod_n[MW+1]);
      frac_sum = {1'b0, prod_n[PW-2 -: MW]} + {{MW{1'b0}}, round_up};
      // Carry out of the fraction leaves it all zero: bump the exponent.
      frac_r   = frac_sum[MW-1:0];
      exp_r    = frac_sum[MW] ? exp_n + EXP_ONE : exp_n;
   end

   assign unused_bits = prod_n[PW-1];
`else
   assign frac_r      = prod_n[PW-2 -: MW];
   assign exp_r       = exp_n;
   assign unused_bits = ^{prod_n[PW-1], prod_n[MW:0]};
`endif

   assign any_nan    = (meta_i.cls_a == NAN) || (meta_i.cls_b == NAN);
   assign inf_x_zero = ((meta_i.cls_a == INF) && (meta_i.cls_b == ZERO)) ||
                       ((meta_i.cls_b == INF) && (meta_i.cls_a == ZERO));
   assign any_inf    = (meta_i.cls_a == INF) || (meta_i.cls_b == INF);
   assign any_zero   = (meta_i.cls_a == ZERO) || (meta_i.cls_b == ZERO);

   always_comb begin
      result_o = '0;
      flags_o  = '0;
      if (any_nan) begin
         result_o = QNAN;
      end else if (inf_x_zero) begin
         result_o        = QNAN;
         flags_o.invalid = 1'b1;
      end else if (any_inf) begin
         result_o = {meta_i.sign, INF_MAG};
      end else if (any_zero) begin
         result_o = {meta_i.sign, {(W-1){1'b0}}};
      end else if (exp_r >= EXP_MAX) begin
         result_o         = {meta_i.sign, INF_MAG};
         flags_o.overflow = 1'b1;
      end else if (exp_r < EXP_ONE) begin
         result_o          = {meta_i.sign, {(W-1){1'b0}}};
         flags_o.underflow = 1'b1;
      end else begin
         result_o = {meta_i.sign, exp_r[EW-1:0], frac_r};
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined floating-point multiplier, one multiply per cycle,
// valid/ready handshake with a single global stall.
//   S1: unpack, classify, sign, exponent sum minus bias
//   S2: (MANTISSA_WIDTH+1)^2 mantissa product
//   S3: normalise / round / range check / pack (fp_round_norm), registered
//       directly onto the outputs
// Configuration macro: FP_MUL_ROUND_EN (round-to-nearest-even when defined,
// truncation otherwise; latency identical).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake, flp_a / flp_b operands
//   out_valid / out_ready: result handshake
//   result               : packed product; sign / exponent / prod are fields
//   overflow, underflow, invalid : flags aligned with result
// ---------------------------------------------------------------------------
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXPONENT_WIDTH = 8,
   parameter int unsigned MANTISSA_WIDTH = 23,
   localparam int unsigned W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              flp_a,
   input  logic [W-1:0]              flp_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [W-1:0]              result,
   output logic                      sign,
   output logic [EXPONENT_WIDTH-1:0] exponent,
   output logic [MANTISSA_WIDTH-1:0] prod,
   output logic                      overflow,
   output logic                      underflow,
   output logic                      invalid
);

   localparam int unsigned EW = EXPONENT_WIDTH;
   localparam int unsigned MW = MANTISSA_WIDTH;
   localparam int unsigned PW = 2 * MW + 2;
   localparam logic signed [EW+1:0] BIAS = (EW+2)'(fp_bias(EW));

   logic                  en;

   logic                  s1_valid_q;
   logic                  s2_valid_q;
   logic                  out_valid_q;

   fp_meta_t              s1_meta_d, s1_meta_q, s2_meta_q;
   logic signed [EW+1:0]  s1_exp_d, s1_exp_q, s2_exp_q;
   logic [MW:0]           s1_ma_d, s1_mb_d, s1_ma_q, s1_mb_q;
   logic [PW-1:0]         s2_prod_d, s2_prod_q;
   logic [W-1:0]          s3_result_d, result_q;
   fp_flags_t             s3_flags_d, flags_q;

   logic [EW-1:0]         ea, eb;
   logic [MW-1:0]         fa, fb;

   // Whole pipeline advances together; it only stops when the output
   // register holds a result nobody has taken.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   assign ea = flp_a[W-2 -: EW];
   assign eb = flp_b[W-2 -: EW];
   assign fa = flp_a[MW-1:0];
   assign fb = flp_b[MW-1:0];

   // S1: unpack and classify.
   always_comb begin
      s1_meta_d.sign  = flp_a[W-1] ^ flp_b[W-1];
      s1_meta_d.cls_a = fp_classify(ea == '0, ea == '1, fa != '0);
      s1_meta_d.cls_b = fp_classify(eb == '0, eb == '1, fb != '0);
      s1_exp_d        = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      s1_ma_d         = {1'b1, fa};
      s1_mb_d         = {1'b1, fb};
   end

   // S2: mantissa product at full width.
   assign s2_prod_d = {{(MW+1){1'b0}}, s1_ma_q} * {{(MW+1){1'b0}}, s1_mb_q};

   // S3: normalise / round / pack.
   fp_round_norm #(
      .EXPONENT_WIDTH (EW),
      .MANTISSA_WIDTH (MW)
   ) u_round_norm (
      .meta_i   (s2_meta_q),
      .exp_i    (s2_exp_q),
      .prod_i   (s2_prod_q),
      .result_o (s3_result_d),
      .flags_o  (s3_flags_d)
   );

   // Stage valids and the visible output; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (en) begin
         s1_valid_q  <= in_valid;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            result_q <= s3_result_d;
            flags_q  <= s3_flags_d;
         end
      end
   end

   // Payload registers need no reset: they are qualified by the valids.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_meta_q <= s1_meta_d;
         s1_exp_q  <= s1_exp_d;
         s1_ma_q   <= s1_ma_d;
         s1_mb_q   <= s1_mb_d;
         s2_meta_q <= s1_meta_q;
         s2_exp_q  <= s1_exp_q;
         s2_prod_q <= s2_prod_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign sign      = result_q[W-1];
   assign exponent  = result_q[W-2 -: EW];
   assign prod      = result_q[MW-1:0];
   assign overflow  = flags_q.overflow;
   assign underflow = flags_q.underflow;
   assign invalid   = flags_q.invalid;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_pipe
// Self-checking bench for fp_mul_pipe (binary32 instance plus a 5/10 split
// instance). Expected values come from constant vectors and from a
// remainder-based arithmetic reference model; a scoreboard follows every
// handshake of the binary32 instance.
// ---------------------------------------------------------------------------
module tb_fp_mul_pipe;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  fl;   // {overflow, underflow, invalid}
   } vec_t;

`ifdef FP_MUL_ROUND_EN
   localparam logic [31:0] RND_RES = 32'h4010_0002;
`else
   localparam logic [31:0] RND_RES = 32'h4010_0001;
`endif

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] flp_a, flp_b, result;
   logic        sign, overflow, underflow, invalid;
   logic [7:0]  exponent;
   logic [22:0] prod;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_flp_a, h_flp_b, h_result;
   logic        h_sign, h_overflow, h_underflow, h_invalid;
   logic [4:0]  h_exponent;
   logic [9:0]  h_prod;

   fp_mul_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .flp_a(flp_a), .flp_b(flp_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .sign(sign), .exponent(exponent), .prod(prod),
      .overflow(overflow), .underflow(underflow), .invalid(invalid)
   );

   fp_mul_pipe #(.EXPONENT_WIDTH(5), .MANTISSA_WIDTH(10)) dut_h (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
      .flp_a(h_flp_a), .flp_b(h_flp_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
      .result(h_result), .sign(h_sign), .exponent(h_exponent), .prod(h_prod),
      .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: exact integer product, scaled down with the discarded part
   // compared against one half ulp; range checked on the final exponent.
   function automatic void model(input longint unsigned a, input longint unsigned b,
                                 input int ew, input int mw,
                                 output longint unsigned res, output logic [2:0] fl);
      longint unsigned emax, fmask, fa, fb, p, q, sbit, qnan;
      int ea, eb, e, sh;
      logic na, nb, ia, ib, za, zb;
      emax  = (64'd1 << ew) - 64'd1;
      fmask = (64'd1 << mw) - 64'd1;
      ea    = int'((a >> mw) & emax);
      eb    = int'((b >> mw) & emax);
      fa    = a & fmask;
      fb    = b & fmask;
      sbit  = (a[ew+mw] ^ b[ew+mw]) ? (64'd1 << (ew + mw)) : 64'd0;
      qnan  = (emax << mw) | (64'd1 << (mw - 1));
      na = (ea == int'(emax)) && (fa != 0);
      nb = (eb == int'(emax)) && (fb != 0);
      ia = (ea == int'(emax)) && (fa == 0);
      ib = (eb == int'(emax)) && (fb == 0);
      za = (ea == 0);
      zb = (eb == 0);
      fl  = 3'b000;
      res = 64'd0;
      if (na || nb) res = qnan;
      else if ((ia && zb) || (ib && za)) begin res = qnan; fl = 3'b001; end
      else if (ia || ib) res = sbit | (emax << mw);
      else if (za || zb) res = sbit;
      else begin
         p = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
         e = ea + eb - ((1 << (ew - 1)) - 1);
         if (p >= (64'd1 << (2 * mw + 1))) begin sh = mw + 1; e++; end
         else sh = mw;
         q = p >> sh;
`ifdef FP_MUL_ROUND_EN
         begin
            longint unsigned rem, half;
            rem  = p & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << (mw + 1))) begin q = q >> 1; e++; end
         end
`endif
         if (e >= int'(emax)) begin res = sbit | (emax << mw); fl = 3'b100; end
         else if (e <= 0) begin res = sbit; fl = 3'b010; end
         else res = sbit | (64'(e) << mw) | (q & fmask);
      end
   endfunction

   function automatic logic [31:0] rand_op32();
      logic [31:0] v;
      int unsigned m;
      v = $urandom();
      m = $urandom_range(0, 15);
      case (m)
         0: v[30:23] = 8'h00;
         1: v[30:23] = 8'hFF;
         2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
         3: v[30:0] = '0;
         4, 5, 6, 7, 8, 9: v[30:23] = 8'($urandom_range(100, 154));
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   function automatic logic [15:0] rand_op16();
      logic [15:0] v;
      v = 16'($urandom());
      if ($urandom_range(0, 3) != 0) v[14:10] = 5'($urandom_range(9, 21));
      return v;
   endfunction

   // Scoreboard for the binary32 instance, sampled on the falling edge.
   logic [34:0] exp_q[$];
   logic        hold_prev = 1'b0;
   logic [34:0] hold_val;

   always @(negedge clk) begin
      logic [34:0]     e;
      longint unsigned r;
      logic [2:0]      f;
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({result, overflow, underflow, invalid}), 64'(hold_val));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("sb_result", 64'(result), 64'(e[34:3]));
               chk("sb_flags", 64'({overflow, underflow, invalid}), 64'(e[2:0]));
            end
         end
         if (in_valid && in_ready) begin
            model(64'(flp_a), 64'(flp_b), 8, 23, r, f);
            exp_q.push_back({r[31:0], f});
         end
         hold_prev = out_valid && !out_ready;
         hold_val  = {result, overflow, underflow, invalid};
      end
   end

   task automatic run_vec(input vec_t v, input string name);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      flp_a     = v.a;
      flp_b     = v.b;
      chk({name, "_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({name, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_res"}, 64'(result), 64'(v.res));
      chk({name, "_fields"}, 64'({sign, exponent, prod}), 64'(v.res));
      chk({name, "_flags"}, 64'({overflow, underflow, invalid}), 64'(v.fl));
   endtask

   task automatic run_half(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic [2:0] ef, input string name);
      @(posedge clk); #1;
      h_in_valid = 1'b1;
      h_flp_a    = a;
      h_flp_b    = b;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk({name, "_valid"}, 64'(h_out_valid), 64'd1);
      chk({name, "_res"}, 64'(h_result), 64'(er));
      chk({name, "_flags"}, 64'({h_overflow, h_underflow, h_invalid}), 64'(ef));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   vec_t tbl[11];

   initial begin
      int               n_acc, idx;
      logic             acc, seen;
      longint unsigned  r;
      logic [2:0]       f;
      logic [15:0]      ha, hb;

      tbl[0]  = '{32'h40A0_0000, 32'h4040_0000, 32'h4170_0000, 3'b000};
      tbl[1]  = '{32'hC240_0000, 32'hC188_0000, 32'h444C_0000, 3'b000};
      tbl[2]  = '{32'h3FC0_0001, 32'h3FC0_0001, RND_RES,       3'b000};
      tbl[3]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001};
      tbl[4]  = '{32'hFFC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000};
      tbl[5]  = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100};
      tbl[6]  = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010};
      tbl[7]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000};
      tbl[8]  = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000};
      tbl[9]  = '{32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 3'b000};
      tbl[10] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flp_a = '0; flp_b = '0;
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_flp_a = '0; h_flp_b = '0;

      // Reset state
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'({overflow, underflow, invalid}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vectors with latency check
      for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Back-pressure: three pairs fill the pipe, then the input stalls
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      idx       = 0;
      flp_a     = tbl[0].a;
      flp_b     = tbl[0].b;
      n_acc     = 0;
      repeat (6) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            idx++;
            flp_a = tbl[idx].a;
            flp_b = tbl[idx].b;
         end
      end
      chk("bp_accepted", 64'(n_acc), 64'd3);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_head", 64'(result), 64'(tbl[0].res));
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_hold", 64'(result), 64'(tbl[0].res));
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_drain%0d_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("bp_drain%0d_res", k), 64'(result), 64'(tbl[k].res));
         @(posedge clk);
      end
      @(negedge clk);
      chk("bp_empty", 64'(out_valid), 64'd0);

      // Reset with two products in flight
      @(posedge clk); #1;
      in_valid = 1'b1; flp_a = tbl[0].a; flp_b = tbl[0].b;
      @(posedge clk); #1;
      flp_a = tbl[1].a; flp_b = tbl[1].b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_stale", 64'(seen), 64'd0);
      run_vec(tbl[1], "post_rst");

      // Narrow format instance
      run_half(16'h4500, 16'h4200, 16'h4B80, 3'b000, "half_5x3");
      for (int i = 0; i < 40; i++) begin
         ha = rand_op16();
         hb = rand_op16();
         model(64'(ha), 64'(hb), 5, 10, r, f);
         run_half(ha, hb, r[15:0], f, $sformatf("half_rnd%0d", i));
      end

      // Randomised traffic with random stalls, checked by the scoreboard
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flp_a     = rand_op32();
         flp_b     = rand_op32();
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
